// File: rtl/led_stretch_drv.sv
// Per-channel LED pulse stretcher: each event input lights an active-low LED for a
// fixed number of prescaled ticks, then enforces a dark gap before the next flash.
module led_stretch_drv #(
   parameter int NCH = 4,
   parameter int PRESCALE = 50000,
   parameter int ON_TICKS = 20,
   parameter int OFF_TICKS = 5
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic [NCH-1:0] EVT,
   input  logic           TEST,
   output logic [NCH-1:0] LED_L,
   output logic [NCH-1:0] BUSY
);

   localparam int PW = $clog2(PRESCALE);
   localparam int MAXT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CW = ($clog2(MAXT) > 0) ? $clog2(MAXT) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
   localparam logic [CW-1:0] ON_LAST = CW'(ON_TICKS - 1);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_TICKS - 1);

   typedef enum logic [1:0] {IDLE, LIT, GAP} state_t;

   logic [NCH-1:0] sync1_q, sync2_q, prev_q;
   logic [NCH-1:0] evt;
   logic [PW-1:0]  presc_q, presc_d;
   logic           tick;
   state_t         state_q [NCH];
   logic [CW-1:0]  cnt_q [NCH];
   logic [NCH-1:0] pend_q;
   logic [NCH-1:0] ledL_q, busy_q;

   // EVT is asynchronous: two flops resolve metastability, the third detects the rise.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= EVT;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign evt = sync2_q & ~prev_q;

   assign tick    = (presc_q == PS_LAST);
   assign presc_d = tick ? '0 : presc_q + PW'(1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // Outputs are registered from the current state, so an event consumed at one edge
   // shows on LED_L one edge later.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= '0;
         end
         pend_q <= '0;
         ledL_q <= '1;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            ledL_q[i] <= ~((state_q[i] == LIT) | TEST);
            busy_q[i] <= (state_q[i] != IDLE);
            unique case (state_q[i])
               IDLE: begin
                  if (evt[i]) begin
                     state_q[i] <= LIT;
                     cnt_q[i]   <= '0;
                  end
               end
               LIT: begin
                  if (evt[i]) pend_q[i] <= 1'b1;
                  if (tick) begin
                     if (cnt_q[i] == ON_LAST) begin
                        state_q[i] <= GAP;
                        cnt_q[i]   <= '0;
                     end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                     end
                  end
               end
               GAP: begin
                  // An event landing on the final gap tick re-lights directly instead of pending.
                  if (tick && (cnt_q[i] == OFF_LAST)) begin
                     cnt_q[i]   <= '0;
                     state_q[i] <= (pend_q[i] | evt[i]) ? LIT : IDLE;
                     pend_q[i]  <= 1'b0;
                  end else begin
                     if (evt[i]) pend_q[i] <= 1'b1;
                     if (tick) cnt_q[i] <= cnt_q[i] + CW'(1);
                  end
               end
               default: begin
                  state_q[i] <= IDLE;
                  cnt_q[i]   <= '0;
               end
            endcase
         end
      end
   end

   assign LED_L = ledL_q;
   assign BUSY  = busy_q;

endmodule

// File: doc/led_stretch_drv.md
LED_STRETCH_DRV -- requirements
Module: led_stretch_drv

Interface
REQ-001 Parameters SHALL be one per line:
  NCH, 4, number of LED channels
  PRESCALE, 50000, CLK cycles per stretch tick (>=2)
  ON_TICKS, 20, ticks an LED stays lit per event (>=1)
  OFF_TICKS, 5, minimum dark ticks between consecutive flashes (>=1)
REQ-002 Ports SHALL be one per line:
  CLK    input   1    system clock; all logic on rising edge
  RST    input   1    asynchronous, active-high reset
  EVT    input   NCH  per-channel event inputs; asynchronous to CLK; rising edge = event
  TEST   input   1    lamp test; high forces every LED lit
  LED_L  output  NCH  active-low LED cathode drive; 0 = lit
  BUSY   output  NCH  high while the channel is not IDLE
REQ-003 There SHALL be one clock (CLK), and reset SHALL be asynchronous and active-high (RST).

Function
REQ-004 Each EVT bit SHALL pass through a two-flop synchroniser followed by a third "previous" flop; event = sync2 AND NOT prev, one CLK cycle wide.
REQ-005 One shared prescaler SHALL count 0..PRESCALE-1 and wrap to 0; TICK SHALL be high for exactly the one cycle in which the count equals PRESCALE-1.
REQ-006 The prescaler SHALL run freely from reset release and SHALL NOT be restarted by events.
REQ-007 Each channel SHALL have an FSM with states IDLE, LIT and GAP, plus a tick counter and a pending flag.
REQ-008 In IDLE, an event SHALL move the channel to LIT and clear its counter.
REQ-009 In LIT, each TICK SHALL increment the counter.
REQ-010 In LIT, a TICK that arrives with the counter at ON_TICKS-1 SHALL move the channel to GAP and clear the counter.
REQ-011 In GAP, a TICK that arrives with the counter at OFF_TICKS-1 SHALL clear the counter and move the channel to LIT if pending=1, clearing pending, or to IDLE otherwise.
REQ-012 An event in LIT or GAP SHALL set pending.
REQ-013 Multiple events before pending clears SHALL collapse into one additional flash.
REQ-014 An event coincident with the terminal TICK of LIT SHALL set pending; the channel still enters GAP.
REQ-015 An event coincident with the terminal TICK of GAP SHALL cause the move to LIT; pending is then left clear.
REQ-016 Only ticks after state entry SHALL count, so LIT lasts (ON_TICKS-1)*PRESCALE+1 to ON_TICKS*PRESCALE cycles and GAP lasts (OFF_TICKS-1)*PRESCALE+1 to OFF_TICKS*PRESCALE cycles.
REQ-017 LED_L[i] SHALL be a registered output, driven low while the channel is in LIT or TEST=1, and high otherwise.
REQ-018 A rising EVT first sampled at CLK edge k SHALL drive LED_L low at edge k+3.
REQ-019 TEST SHALL affect LED_L only; FSMs, counters and pending SHALL continue unaffected. LED_L follows TEST with one registered cycle of latency.
REQ-020 BUSY[i] SHALL be registered and high in LIT or GAP.
REQ-021 Channels SHALL be fully independent; simultaneous events on all channels SHALL all be honoured.
REQ-022 Counter widths SHALL be $clog2 of the respective parameter, and no counter SHALL overflow for any legal parameter set.

Reset
REQ-023 While RST=1: LED_L = all ones, BUSY = 0, every FSM in IDLE, counters = 0, pending = 0, prescaler = 0, all synchroniser flops = 0.
REQ-024 If RST is asserted mid-flash, LED_L SHALL go high asynchronously without waiting for CLK.
REQ-025 If EVT is already high at reset release, it SHALL be treated as a rising edge and produce one flash.
REQ-026 Reset release SHALL be synchronised externally; the block SHALL assume deassertion away from the CLK edge.

Verification
Bench parameters: NCH=4, PRESCALE=4, ON_TICKS=3, OFF_TICKS=2.
REQ-027 Single 1-cycle EVT[0] pulse first sampled at edge k -> LED_L[0]=0 from edge k+3 for 9..12 cycles, then 1; BUSY[0] stays high a further 5..8 cycles, then returns to 0; other channels untouched.
REQ-028 Second EVT[1] edge during LIT plus a third during GAP -> exactly two flashes separated by a 5..8 cycle dark gap, then IDLE.
REQ-029 Event on the same cycle as the terminal LIT TICK -> GAP entered, then a second flash.
REQ-030 Event on the same cycle as the terminal GAP TICK -> immediate re-light and no third flash.
REQ-031 TEST=1 for 10 cycles with no events -> LED_L=0000 one cycle after TEST rises and 1111 one cycle after it falls; BUSY stays 0.
REQ-032 RST pulsed mid-LIT -> LED_L=1111 and BUSY=0 immediately.
REQ-033 RST released with EVT[2] held high -> exactly one flash on channel 2.
REQ-034 All four EVT bits rising together -> four identical flash waveforms.
